// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings,
// default latencies and the sequencer state type.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Combinational signed/unsigned 32-bit divider. Quotient truncates toward
// zero, remainder takes the sign of the dividend; flags a zero divisor.
module md_div_core (
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide magnitudes, then restore signs; a zero divisor is replaced so
    // the divider never sees 0 (its result is discarded by the caller).
    always_comb begin
        a_neg    = is_signed & a[31];
        b_neg    = is_signed & b[31];
        a_mag    = a_neg ? (32'd0 - a) : a;
        b_mag    = b_neg ? (32'd0 - b) : b;
        div_zero = (b == '0);
        b_safe   = div_zero ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed in
// the issue cycle, held in shadow registers and committed after a fixed
// latency so the pipeline observes multi-cycle mult/div behaviour.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_active
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    md_op_e          op;
    md_state_e       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     hi_nxt, hi_nxt_d, lo_nxt, lo_nxt_d;
    logic            wr_pend_q, wr_pend_d;

    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic [31:0]     quot;
    logic [31:0]     rem;
    logic            div_zero;

    assign op     = md_op_e'(md_op);
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    md_div_core u_div (
        .is_signed (op == MD_DIV),
        .a         (A),
        .b         (B),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    // Next-state, counter, shadow and HI/LO update selection.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_nxt_d  = hi_nxt;
        lo_nxt_d  = lo_nxt;
        wr_pend_d = wr_pend_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            hi_nxt_d  = (op == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
                            lo_nxt_d  = (op == MD_MULT) ? prod_s[31:0]  : prod_u[31:0];
                            wr_pend_d = 1'b1;
                            count_d   = CW'(MULT_CYCLES);
                            state_d   = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Zero divisor still occupies the full latency
                            // but suppresses the final write-back.
                            hi_nxt_d  = rem;
                            lo_nxt_d  = quot;
                            wr_pend_d = ~div_zero;
                            count_d   = CW'(DIV_CYCLES);
                            state_d   = MD_RUN;
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                if (count_q == CW'(1)) begin
                    if (wr_pend_q) begin
                        hi_d = hi_nxt;
                        lo_d = lo_nxt;
                    end
                    wr_pend_d = 1'b0;
                    count_d   = '0;
                    state_d   = MD_IDLE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State, counter, shadow and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_nxt    <= '0;
            lo_nxt    <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_nxt    <= hi_nxt_d;
            lo_nxt    <= lo_nxt_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    assign busy      = (state_q == MD_RUN);
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign md_active = start | busy;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed results.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        md_active;

    int checks;
    int errors;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .HI        (HI),
        .LO        (LO),
        .md_active (md_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one start pulse; returns #1 after the issuing edge.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        #1;
        check32("md_active_issue", {31'd0, md_active}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = MD_NONE;
        A     = '0;
        B     = '0;
    endtask

    // Count cycles with busy high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, a, b);
        count_busy(n);
        check32({tag, "_cycles"}, n, cyc);
        check32({tag, "_hi"}, HI, exp_hi);
        check32({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = MD_NONE;
        A      = '0;
        B      = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_hi", HI, 32'd0);
        check32("reset_lo", LO, 32'd0);
        check32("reset_active", {31'd0, md_active}, 32'd0);

        // MULT -2*3, with HI/LO held during the run
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        check32("mult_mid_busy", {31'd0, busy}, 32'd1);
        check32("mult_mid_hi", HI, 32'd0);
        check32("mult_mid_lo", LO, 32'd0);
        count_busy(n);
        check32("mult_cycles", n, 32'd5);
        check32("mult_hi", HI, 32'hFFFF_FFFF);
        check32("mult_lo", LO, 32'hFFFF_FFFA);

        run_op("mult_negneg", MD_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFC, 5, 32'h0,         32'h14);
        run_op("multu",       MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h1);
        run_op("div_neg",     MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb",    MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h1,         32'hFFFF_FFFD);
        run_op("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0,         32'h8000_0000);
        run_op("divu",        MD_DIVU,  32'd100,       32'd7,         10, 32'd2,         32'd14);

        // Move-to then divide by zero
        issue(MD_MTHI, 32'h11, 32'd0);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        check32("mthi_hi", HI, 32'h11);
        issue(MD_MTLO, 32'h22, 32'd0);
        check32("mtlo_lo", LO, 32'h22);
        run_op("divu_zero", MD_DIVU, 32'd55, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_zero",  MD_DIV,  32'd55, 32'd0, 10, 32'h11, 32'h22);

        issue(MD_MTLO, 32'h1234, 32'd0);
        check32("mtlo2_busy", {31'd0, busy}, 32'd0);
        check32("mtlo2_lo", LO, 32'h1234);
        check32("mtlo2_hi", HI, 32'h11);

        issue(MD_NONE, 32'hDEAD_BEEF, 32'd1);
        check32("none_busy", {31'd0, busy}, 32'd0);
        check32("none_hi", HI, 32'h11);
        check32("none_lo", LO, 32'h1234);

        // DIVU with an ignored MULT start in busy cycle 3
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; A = 32'd2; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE; A = '0; B = '0;
        count_busy(n);
        check32("ignore_cycles", n, 32'd7);
        check32("ignore_hi", HI, 32'd2);
        check32("ignore_lo", LO, 32'd14);

        // DIVU with ignored start in cycle 3 and reset in cycle 6
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; A = 32'd2; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = MD_NONE; A = '0; B = '0;
        check32("abort_busy_c4", {31'd0, busy}, 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_hi", HI, 32'd0);
        check32("abort_lo", LO, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check32("abort_late_busy", {31'd0, busy}, 32'd0);
        check32("abort_late_hi", HI, 32'd0);
        check32("abort_late_lo", LO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
